// File: rtl/datamem_dump_unit.sv
// Result-extraction engine: after the core reaches HALT_PC, reads a programmed window of
// data-memory words through a one-cycle-latency port and streams them out over valid/ready.
module datamem_dump_unit #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] HALT_PC = 32'h108
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W-1:0] start_idx,
  input  logic [ADDR_W-1:0] end_idx,
  input  logic [31:0]       pc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W+1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StRead  = 3'd2,
    StWait  = 3'd3,
    StSend  = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W+1:0]   out_addr_q, out_addr_d;
  logic                out_last_q, out_last_d;
  logic                mem_rd_en_q, out_valid_q, busy_q, done_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    start_d    = start_q;
    end_d      = end_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    out_last_d = out_last_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          start_d = start_idx;
          end_d   = end_idx;
          idx_d   = start_idx;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (pc == HALT_PC) begin
          // An inverted window finishes without touching memory.
          state_d = (start_q <= end_q) ? StRead : StDone;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        out_data_d = mem_rd_data;
        out_addr_d = {idx_q, 2'b00};
        out_last_d = (idx_q == end_q);
        state_d    = StSend;
      end
      StSend: begin
        if (out_ready) begin
          out_last_d = 1'b0;
          if (out_last_q) begin
            state_d = StDone;
          end else begin
            // Only reached when idx < end, so the increment never wraps.
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      start_q     <= '0;
      end_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      mem_rd_en_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      end_q       <= end_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      mem_rd_en_q <= (state_d == StRead);
      out_valid_q <= (state_d == StSend);
      busy_q      <= (state_d == StArmed) || (state_d == StRead) ||
                     (state_d == StWait) || (state_d == StSend);
      done_q      <= (state_d == StDone);
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = idx_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_datamem_dump_unit.sv
// Self-checking bench for datamem_dump_unit: window-level model (expected word and read queues)
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_datamem_dump_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic [6:0]  start_idx, end_idx;
  logic [31:0] pc;
  logic        mem_rd_en;
  logic [6:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [8:0]  out_addr;
  logic        out_last, busy, done;

  datamem_dump_unit dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .start_idx  (start_idx),
    .end_idx    (end_idx),
    .pc         (pc),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [128];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    logic [31:0] d;
    logic [8:0]  a;
    logic        l;
  } word_t;

  word_t exp_q[$];
  int    rd_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    n_rx, rd_pulses, valid_cycles, halt_cyc;
  logic [31:0] log_d [16];
  logic [8:0]  log_a [16];
  logic        log_l [16];
  int          log_c [16];
  int          nom_d [4] = '{11, 22, 33, 44};
  int          nom_a [4] = '{268, 272, 276, 280};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the window model.
  logic  held = 1'b0;
  word_t held_w;
  always @(negedge clk) begin
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_pulses++;
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          chk("rd_addr", 64'(mem_rd_addr), 64'(rd_q[0]));
          void'(rd_q.pop_front());
        end
      end
      chk("rd_valid_excl", 64'(mem_rd_en & out_valid), 0);
      chk("busy_done_excl", 64'(busy & done), 0);
      if (held) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_data", 64'(out_data), 64'(held_w.d));
        chk("hold_addr", 64'(out_addr), 64'(held_w.a));
        chk("hold_last", 64'(out_last), 64'(held_w.l));
      end
      held = 1'b0;
      if (out_valid) begin
        valid_cycles++;
        if (out_ready) begin
          if (exp_q.size() == 0) chk("word_unexpected", 1, 0);
          else begin
            chk("word_data", 64'(out_data), 64'(exp_q[0].d));
            chk("word_addr", 64'(out_addr), 64'(exp_q[0].a));
            chk("word_last", 64'(out_last), 64'(exp_q[0].l));
            void'(exp_q.pop_front());
          end
          if (n_rx < 16) begin
            log_d[n_rx] = out_data;
            log_a[n_rx] = out_addr;
            log_l[n_rx] = out_last;
            log_c[n_rx] = cyc;
          end
          n_rx++;
        end else begin
          held   = 1'b1;
          held_w = '{out_data, out_addr, out_last};
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    exp_q.delete();
    rd_q.delete();
    n_rx = 0;
    rd_pulses = 0;
    valid_cycles = 0;
  endtask

  task automatic arm_win(input int s, input int e);
    reset_model();
    if (s <= e) begin
      for (int i = s; i <= e; i++) begin
        exp_q.push_back('{mem[i], 9'(i * 4), (i == e)});
        rd_q.push_back(i);
      end
    end
    start_idx = 7'(s);
    end_idx   = 7'(e);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string name);
    int n = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 64'(done), 1);
    chk({name, "_busy"}, 64'(busy), 0);
    chk({name, "_words_left"}, 64'(exp_q.size()), 0);
    chk({name, "_reads_left"}, 64'(rd_q.size()), 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, 64'(out_valid), 1);
  endtask

  task automatic chk_nominal(input string tag);
    chk({tag, "_count"}, 64'(n_rx), 4);
    chk({tag, "_rd_pulses"}, 64'(rd_pulses), 4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_lit_data"}, 64'(log_d[i]), 64'(nom_d[i]));
      chk({tag, "_lit_addr"}, 64'(log_a[i]), 64'(nom_a[i]));
      chk({tag, "_lit_last"}, 64'(log_l[i]), (i == 3) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_mem_rd_en"}, 64'(mem_rd_en), 0);
    chk({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 0);
    chk({tag, "_out_data"}, 64'(out_data), 0);
    chk({tag, "_out_addr"}, 64'(out_addr), 0);
    chk({tag, "_out_last"}, 64'(out_last), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; arm = 1'b0; start_idx = '0; end_idx = '0; pc = '0; out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[67] = 32'd11; mem[68] = 32'd22; mem[69] = 32'd33; mem[70] = 32'd44;
    mem[127] = 32'hDEADBEEF;
    reset_model();

    // Reset values
    repeat (3) tick();
    chk_all_zero("reset_held");
    rst = 1'b1;
    tick();
    chk_all_zero("reset_released");

    // Nominal dump with out_ready high
    out_ready = 1'b1;
    arm_win(67, 70);
    chk("nom_busy_armed", 64'(busy), 1);
    tick();
    chk("nom_no_read_before_halt", 64'(rd_pulses), 0);
    pc = 32'h108;
    halt_cyc = cyc;
    wait_done(40, "nom_done");
    chk_nominal("nom");
    chk("nom_latency", 64'(log_c[0] - halt_cyc), 3);
    for (int i = 1; i < 4; i++) chk("nom_gap", 64'(log_c[i] - log_c[i-1]), 3);
    repeat (4) tick();
    chk("nom_done_sticky", 64'(done), 1);
    chk("nom_halt_in_done_no_read", 64'(rd_pulses), 4);
    pc = 32'h0;

    // Backpressure: 5 stalled cycles on every word
    out_ready = 1'b0;
    arm_win(67, 70);
    chk("bp_done_drops", 64'(done), 0);
    pc = 32'h108;
    for (int w = 0; w < 4; w++) begin
      wait_valid("bp_valid");
      repeat (5) tick();
      chk("bp_still_valid", 64'(out_valid), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_done(20, "bp_done");
    chk_nominal("bp");
    chk("bp_valid_cycles", 64'(valid_cycles), 24);
    pc = 32'h0;

    // Single-word window at the top of memory
    out_ready = 1'b1;
    arm_win(127, 127);
    pc = 32'h108;
    wait_done(20, "top_done");
    chk("top_count", 64'(n_rx), 1);
    chk("top_data", 64'(log_d[0]), 64'hDEADBEEF);
    chk("top_addr", 64'(log_a[0]), 508);
    chk("top_last", 64'(log_l[0]), 1);
    chk("top_rd_pulses", 64'(rd_pulses), 1);
    pc = 32'h0;

    // Inverted window: nothing read or emitted
    arm_win(10, 5);
    pc = 32'h108;
    wait_done(10, "inv_done");
    chk("inv_valid_cycles", 64'(valid_cycles), 0);
    chk("inv_rd_pulses", 64'(rd_pulses), 0);
    pc = 32'h0;

    // Halt gating, transient halt pc, and an ignored re-arm mid-dump
    arm_win(67, 70);
    for (int p = 0; p <= 32'h104; p += 4) begin
      pc = 32'(p);
      tick();
    end
    chk("gate_no_read", 64'(rd_pulses), 0);
    chk("gate_busy", 64'(busy), 1);
    pc = 32'h108;
    tick();
    pc = 32'h10C;
    while (n_rx < 1 && cyc < 100000) tick();
    start_idx = 7'd0;
    end_idx   = 7'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_done(40, "rearm_done");
    chk_nominal("rearm");
    pc = 32'h0;

    // Asynchronous reset during SEND of word 2, then a clean re-dump
    out_ready = 1'b0;
    arm_win(67, 70);
    pc = 32'h108;
    wait_valid("rst_w1_valid");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("rst_w2_valid");
    #2 rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    reset_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk_all_zero("rst_after");
    pc = 32'h0;
    out_ready = 1'b1;
    arm_win(67, 70);
    pc = 32'h108;
    wait_done(40, "redump_done");
    chk_nominal("redump");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
